id_stage_pipe: RTL and testbench

//  Registered decode stage between fetch and execute. Accepts {pc, instr} with valid/ready and

---
 rtl/id_stage_pipe.sv | 243 ++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// RV32I decode stage with a 2-entry skid buffer and a registered in_ready.
// Optional macro ID_ILLEGAL_TRAP_EN: strict funct checking; illegal bundles stall the stage until flush.
module id_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [31:0]         in_instr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [9:0]          out_class,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [2:0]          out_br_f3,
    output logic [4:0]          out_rs1,
    output logic [4:0]          out_rs2,
    output logic [4:0]          out_rd,
    output logic [XLEN-1:0]     out_imm
);

    localparam int C_R     = 0;
    localparam int C_IMM   = 1;
    localparam int C_LUI   = 2;
    localparam int C_LW    = 3;
    localparam int C_SW    = 4;
    localparam int C_BR    = 5;
    localparam int C_JAL   = 6;
    localparam int C_JALR  = 7;
    localparam int C_AUIPC = 8;
    localparam int C_ILL   = 9;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [9:0]          cls;
        logic [ALU_OP_W-1:0] alu_op;
        logic [2:0]          br_f3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [4:0]          rd;
        logic [XLEN-1:0]     imm;
    } bundle_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    function automatic logic [XLEN-1:0] sext(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    bundle_t dec;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

`ifdef ID_ILLEGAL_TRAP_EN
    logic f7_bad, funct_ill;
    assign f7_bad    = !(f7 == 7'h00 || f7 == 7'h20) ||
                       (f7 == 7'h20 && !(f3 == 3'b000 || f3 == 3'b101));
    assign funct_ill = (opc == OP_R && f7_bad) ||
                       (opc == OP_IMM && (f3 == 3'b001 || f3 == 3'b101) && f7_bad) ||
                       ((opc == OP_LW || opc == OP_SW) && f3 != 3'b010);
`endif

    // Decode is purely a function of the incoming word; only present fields are populated.
    always_comb begin
        dec    = '0;
        dec.pc = in_pc;
        case (opc)
            OP_R: begin
                dec.cls[C_R]      = 1'b1;
                dec.rs1           = in_instr[19:15];
                dec.rs2           = in_instr[24:20];
                dec.rd            = in_instr[11:7];
                dec.alu_op[3:0]   = {f7[5], f3};
            end
            OP_IMM: begin
                dec.cls[C_IMM]    = 1'b1;
                dec.rs1           = in_instr[19:15];
                dec.rd            = in_instr[11:7];
                dec.imm           = sext(imm_i);
                dec.alu_op[3:0]   = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
            end
            OP_LUI: begin
                dec.cls[C_LUI]    = 1'b1;
                dec.rd            = in_instr[11:7];
                dec.imm           = sext(imm_u);
                dec.alu_op[3:0]   = 4'b0001;
            end
            OP_LW: begin
                dec.cls[C_LW]     = 1'b1;
                dec.rs1           = in_instr[19:15];
                dec.rd            = in_instr[11:7];
                dec.imm           = sext(imm_i);
            end
            OP_SW: begin
                dec.cls[C_SW]     = 1'b1;
                dec.rs1           = in_instr[19:15];
                dec.rs2           = in_instr[24:20];
                dec.imm           = sext(imm_s);
            end
            OP_BR: begin
                dec.cls[C_BR]     = 1'b1;
                dec.rs1           = in_instr[19:15];
                dec.rs2           = in_instr[24:20];
                dec.imm           = sext(imm_b);
                dec.br_f3         = f3;
                dec.alu_op[3:0]   = 4'b1000;
            end
            OP_JAL: begin
                dec.cls[C_JAL]    = 1'b1;
                dec.rd            = in_instr[11:7];
                dec.imm           = sext(imm_j);
            end
            OP_JALR: begin
                dec.cls[C_JALR]   = 1'b1;
                dec.rs1           = in_instr[19:15];
                dec.rd            = in_instr[11:7];
                dec.imm           = sext(imm_i);
            end
            OP_AUIPC: begin
                dec.cls[C_AUIPC]  = 1'b1;
                dec.rd            = in_instr[11:7];
                dec.imm           = sext(imm_u);
            end
            default: dec.cls[C_ILL] = 1'b1;
        endcase
`ifdef ID_ILLEGAL_TRAP_EN
        if (funct_ill) begin
            dec          = '0;
            dec.pc       = in_pc;
            dec.cls[C_ILL] = 1'b1;
        end
`endif
    end

    state_t  state_q, state_d;
    bundle_t out_q, out_d, skid_q, skid_d;
    logic    in_ready_q, in_ready_d;
    logic    accept, pop, pop_block, lock_next;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q & ~flush;
    assign pop       = out_valid & out_ready & ~pop_block & ~flush;

`ifdef ID_ILLEGAL_TRAP_EN
    // An illegal bundle closes the input and parks in the output register until flush.
    logic lock_q, lock_d;
    assign lock_d    = flush ? 1'b0 : (lock_q | (accept & dec.cls[C_ILL]));
    assign lock_next = lock_d;
    assign pop_block = out_q.cls[C_ILL];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= 1'b0;
        else        lock_q <= lock_d;
    end
`else
    assign lock_next = 1'b0;
    assign pop_block = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    out_d   = dec;
                    state_d = ONE;
                end
                ONE: begin
                    if (accept && pop) begin
                        out_d = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (pop) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != FULL) && !lock_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    assign out_pc     = out_q.pc;
    assign out_class  = out_q.cls;
    assign out_alu_op = out_q.alu_op;
    assign out_br_f3  = out_q.br_f3;
    assign out_rs1    = out_q.rs1;
    assign out_rs2    = out_q.rs2;
    assign out_rd     = out_q.rd;
    assign out_imm    = out_q.imm;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode values, skid buffering, flush and reset behaviour.
module tb_id_stage_pipe;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_instr, out_pc, out_imm;
    logic [9:0]  out_class;
    logic [3:0]  out_alu_op;
    logic [2:0]  out_br_f3;
    logic [4:0]  out_rs1, out_rs2, out_rd;

    int vectors    = 0;
    int miscompares = 0;

    id_stage_pipe #(.XLEN(32), .ALU_OP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_class(out_class), .out_alu_op(out_alu_op), .out_br_f3(out_br_f3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0;
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_class", out_class, 0);
        chk("rst_imm", out_imm, 0);
        rst_n = 1'b1;

        // addi x1,x0,10
        out_ready = 1'b1;
        send(32'h100, 32'h00A00093);
        chk("addi_valid", out_valid, 1);
        chk("addi_class", out_class, 10'h002);
        chk("addi_alu", out_alu_op, 4'h0);
        chk("addi_rd", out_rd, 1);
        chk("addi_rs1", out_rs1, 0);
        chk("addi_imm", out_imm, 10);
        chk("addi_pc", out_pc, 32'h100);
        step();
        chk("addi_drain", out_valid, 0);

        // Back-pressure: two accepted, third refused, then all three in order
        out_ready = 1'b0;
        send(32'h200, 32'h00100193);
        chk("bp_rdy_after_1", in_ready, 1);
        send(32'h204, 32'h00200213);
        chk("bp_rdy_full", in_ready, 0);
        chk("bp_out_pc_a", out_pc, 32'h200);
        in_valid = 1'b1; in_pc = 32'h208; in_instr = 32'h00300293;
        step();
        chk("bp_rdy_third", in_ready, 0);
        chk("bp_hold_pc", out_pc, 32'h200);
        chk("bp_hold_rd", out_rd, 3);
        out_ready = 1'b1;
        step();
        chk("bp_b_pc", out_pc, 32'h204);
        chk("bp_b_imm", out_imm, 2);
        step();
        in_valid = 1'b0;
        chk("bp_c_pc", out_pc, 32'h208);
        chk("bp_c_rd", out_rd, 5);
        chk("bp_c_valid", out_valid, 1);
        step();
        chk("bp_drain", out_valid, 0);

        // sub x2,x1,x2 then beq x0,x0,-4
        send(32'h400, 32'h40208133);
        chk("sub_class", out_class, 10'h001);
        chk("sub_alu", out_alu_op, 4'h8);
        chk("sub_rs1", out_rs1, 1);
        chk("sub_rs2", out_rs2, 2);
        chk("sub_rd", out_rd, 2);
        send(32'h404, 32'hFE000EE3);
        chk("beq_class", out_class, 10'h020);
        chk("beq_f3", out_br_f3, 0);
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        chk("beq_alu", out_alu_op, 4'h8);
        chk("beq_rd", out_rd, 0);
        // sw x2,-8(x1)
        send(32'h408, 32'hFE20AC23);
        chk("sw_class", out_class, 10'h010);
        chk("sw_imm", out_imm, 32'hFFFFFFF8);
        chk("sw_rs2", out_rs2, 2);
        chk("sw_rd", out_rd, 0);
        // jal x1,8
        send(32'h40C, 32'h008000EF);
        chk("jal_class", out_class, 10'h040);
        chk("jal_imm", out_imm, 8);
        chk("jal_rd", out_rd, 1);
        step();
        chk("dec_drain", out_valid, 0);

        // Flush from FULL with a valid input present
        out_ready = 1'b0;
        send(32'h300, 32'h00100193);
        send(32'h304, 32'h00200213);
        chk("fl_full", in_ready, 0);
        in_valid = 1'b1; in_pc = 32'h308; in_instr = 32'h00300293; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        // Flush from ONE while in_ready=1: the same-cycle input must vanish
        send(32'h30C, 32'h00100193);
        in_valid = 1'b1; in_pc = 32'h310; in_instr = 32'h00200213; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl1_valid", out_valid, 0);
        step();
        chk("fl1_stays_empty", out_valid, 0);
        chk("fl1_ready", in_ready, 1);
        out_ready = 1'b1;

        // lui x10 / auipc x10
        send(32'h600, 32'h12345537);
        chk("lui_class", out_class, 10'h004);
        chk("lui_alu", out_alu_op, 4'h1);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_rd", out_rd, 10);
        send(32'h604, 32'h00000517);
        chk("auipc_class", out_class, 10'h100);
        chk("auipc_imm", out_imm, 0);
        chk("auipc_pc", out_pc, 32'h604);
        step();

        // Unknown opcode
        send(32'h700, 32'h0000007F);
        chk("ill_class", out_class, 10'h200);
        chk("ill_alu", out_alu_op, 0);
        chk("ill_imm", out_imm, 0);
        chk("ill_rd", out_rd, 0);
        step();
`ifdef ID_ILLEGAL_TRAP_EN
        chk("trap_hold_valid", out_valid, 1);
        chk("trap_hold_ready", in_ready, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("trap_flush_valid", out_valid, 0);
        chk("trap_flush_ready", in_ready, 1);
        send(32'h704, 32'h80000033);
        chk("trap_f7_class", out_class, 10'h200);
        step();
        chk("trap_f7_hold", out_valid, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("trap_f7_flush", out_valid, 0);
`else
        chk("ill_flows", out_valid, 0);
        chk("ill_ready", in_ready, 1);
        send(32'h704, 32'h80000033);
        chk("f7_unchecked_class", out_class, 10'h001);
        chk("f7_unchecked_alu", out_alu_op, 0);
        step();
`endif

        // Asynchronous reset while a bundle is held
        out_ready = 1'b0;
        send(32'h500, 32'h00100193);
        chk("ar_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ready", in_ready, 1);
        chk("ar_pc", out_pc, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_after", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
